// File: rtl/sobel_pkg.sv
// Shared constants and state encoding for the Sobel magnitude scheduler.
package sobel_pkg;

  localparam int DEF_CONV_W     = 29;
  localparam int DEF_SQRT_IN_W  = 60;
  localparam int DEF_SQRT_OUT_W = 30;
  localparam int DEF_WIN        = 9;

  // Four extra bits hold the sum of up to 16 roots without saturation.
  localparam int SUM_MARGIN = 4;
  localparam int DEF_SUM_W  = DEF_SQRT_OUT_W + SUM_MARGIN;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SQ_ISSUE,
    SQ_WAIT,
    THRESH,
    EMIT
  } state_t;

endpackage

// File: rtl/sobel_mag_sq.sv
// Combinational |ix|^2 + |iy|^2 for one two's-complement gradient pair.
module sobel_mag_sq import sobel_pkg::*; #(
  parameter int CONV_W    = DEF_CONV_W,
  parameter int SQRT_IN_W = DEF_SQRT_IN_W
) (
  input  logic [CONV_W-1:0]    ix,
  input  logic [CONV_W-1:0]    iy,
  output logic [SQRT_IN_W-1:0] mag_sq
);

  logic [CONV_W-1:0]    abs_x;
  logic [CONV_W-1:0]    abs_y;
  logic [SQRT_IN_W-1:0] wide_x;
  logic [SQRT_IN_W-1:0] wide_y;

  // The most negative input negates to itself, which read unsigned is its magnitude.
  always_comb begin
    abs_x  = ix[CONV_W-1] ? (~ix + CONV_W'(1)) : ix;
    abs_y  = iy[CONV_W-1] ? (~iy + CONV_W'(1)) : iy;
    wide_x = SQRT_IN_W'(abs_x);
    wide_y = SQRT_IN_W'(abs_y);
    mag_sq = (wide_x * wide_x) + (wide_y * wide_y);
  end

endmodule

// File: rtl/sobel_mag_sched.sv
// Collects a window of gradient pairs, schedules their roots on a shared sqrt
// unit, and emits one edge decision per entry against the window mean.
module sobel_mag_sched import sobel_pkg::*; #(
  parameter int CONV_W     = DEF_CONV_W,
  parameter int SQRT_IN_W  = DEF_SQRT_IN_W,
  parameter int SQRT_OUT_W = DEF_SQRT_OUT_W,
  parameter int WIN        = DEF_WIN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CONV_W-1:0]     in_ix,
  input  logic [CONV_W-1:0]     in_iy,
  output logic                  sq_start,
  output logic [SQRT_IN_W-1:0]  sq_num,
  input  logic                  sq_done,
  input  logic [SQRT_OUT_W-1:0] sq_root,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_edge,
  output logic                  out_last,
  output logic                  frame_done
);

  localparam int KW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int SW = SQRT_OUT_W + SUM_MARGIN;
  localparam logic [KW-1:0] K_LAST = KW'(WIN - 1);

  state_t state;
  state_t next_state;

  logic [KW-1:0]         k;
  logic [SW-1:0]         sum;
  logic [SQRT_OUT_W-1:0] thr;
  logic [SQRT_IN_W-1:0]  num  [WIN];
  logic [SQRT_OUT_W-1:0] root [WIN];
  logic [SQRT_IN_W-1:0]  mag_sq;
  logic                  at_last;

  sobel_mag_sq #(
    .CONV_W    (CONV_W),
    .SQRT_IN_W (SQRT_IN_W)
  ) u_mag_sq (
    .ix     (in_ix),
    .iy     (in_iy),
    .mag_sq (mag_sq)
  );

  assign at_last = (k == K_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable) next_state = COLLECT;
      COLLECT:  if (in_valid && at_last) next_state = SQ_ISSUE;
      SQ_ISSUE: next_state = SQ_WAIT;
      SQ_WAIT:  if (sq_done) next_state = at_last ? THRESH : SQ_ISSUE;
      THRESH:   next_state = EMIT;
      EMIT:     if (out_ready && at_last) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // sq_num reads the buffer at k, which only moves on sq_done, so it holds through SQ_WAIT.
  always_comb begin
    in_ready  = (state == COLLECT);
    sq_start  = (state == SQ_ISSUE);
    sq_num    = ((state == SQ_ISSUE) || (state == SQ_WAIT)) ? num[k] : '0;
    out_valid = (state == EMIT);
    out_edge  = (state == EMIT) && (root[k] > thr);
    out_last  = (state == EMIT) && at_last;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k          <= '0;
      sum        <= '0;
      thr        <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        num[i]  <= '0;
        root[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          k   <= '0;
          sum <= '0;
        end
        COLLECT: if (in_valid) begin
          num[k] <= mag_sq;
          k      <= at_last ? '0 : k + KW'(1);
        end
        SQ_WAIT: if (sq_done) begin
          root[k] <= sq_root;
          sum     <= sum + SW'(sq_root);
          if (!at_last) k <= k + KW'(1);
        end
        THRESH: begin
          thr <= SQRT_OUT_W'(sum / SW'(WIN));
          k   <= '0;
        end
        EMIT: if (out_ready) begin
          k          <= at_last ? '0 : k + KW'(1);
          frame_done <= at_last;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sobel_mag_sched.md
SOBEL_MAG_SCHED -- requirements
Module: sobel_mag_sched

Interface
REQ-001 Parameters (name, default, meaning): CONV_W, 29, signed gradient width; SQRT_IN_W, 60, radicand width; SQRT_OUT_W, 30, root width; WIN, 9, window entries per frame.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  permits IDLE->COLLECT.
REQ-005 in_valid  in  1; in_ready  out  1; in_ix, in_iy  in  CONV_W each, two's-complement gradient pair.
REQ-006 sq_start  out  1, one-cycle request; sq_num  out  SQRT_IN_W, radicand; sq_done  in  1; sq_root  in  SQRT_OUT_W. These form the port to the shared iterative sqrt unit.
REQ-007 out_valid  out  1; out_ready  in  1; out_edge  out  1, edge decision; out_last  out  1, marks entry WIN-1.
REQ-008 frame_done  out  1  one-cycle pulse after the last output is accepted.

Function
REQ-009 States: IDLE, COLLECT, SQ_ISSUE, SQ_WAIT, THRESH, EMIT; the index register k runs 0..WIN-1.
REQ-010 IDLE: clear k and sum; go to COLLECT when enable=1.
REQ-011 COLLECT: in_ready=1. On in_valid&in_ready, store num[k] = |ix|^2 + |iy|^2 and increment k. After the WIN-th accept, set k=0 and go to SQ_ISSUE. in_ready=0 in every other state.
REQ-012 abs is two's-complement negate when MSB=1. -2^(CONV_W-1) maps to 2^(CONV_W-1) without overflow. The squares and their sum are computed unsigned in SQRT_IN_W bits; the worst case 2^57 fits.
REQ-013 SQ_ISSUE: sq_start=1 for exactly one cycle with sq_num=num[k], then go to SQ_WAIT.
REQ-014 SQ_WAIT: hold sq_num stable and keep sq_start=0. On sq_done: root[k]=sq_root and sum+=sq_root. If k=WIN-1, go to THRESH; otherwise increment k and go to SQ_ISSUE.
REQ-015 sq_done is ignored in every state except SQ_WAIT. sq_done asserted in the same cycle as sq_start is ignored; the sqrt unit latency is at least 1 cycle.
REQ-016 sum is SQRT_OUT_W+4 bits unsigned and saturation-free, because WIN*(2^SQRT_OUT_W-1) fits.
REQ-017 THRESH: thr = floor(sum/WIN), registered in one cycle; then set k=0 and go to EMIT.
REQ-018 EMIT: out_valid=1, out_edge=(root[k] > thr) (strict compare), out_last=(k=WIN-1). All outputs stay stable while out_ready=0.
REQ-019 EMIT handshake: on out_valid&out_ready, increment k. On the last accept, pulse frame_done for one cycle and go to IDLE.
REQ-020 Latency: first out_valid occurs at least 2 cycles after the final sq_done.
REQ-021 If enable=0 in IDLE, the block stays idle. enable is not sampled in any other state; a frame always completes.

Reset
REQ-022 While reset=0, every output and register is forced, asynchronously, to 0 and the state to IDLE. This covers in_ready, sq_start, sq_num, out_valid, out_edge, out_last, frame_done, k, sum, thr, num[], root[].
REQ-023 Reset asserted mid-frame, including during SQ_WAIT, abandons the frame. A later sq_done for the abandoned request is ignored per REQ-015.
REQ-024 Release of reset is synchronous to clk. The first IDLE->COLLECT transition occurs no earlier than the first edge after release.

Structure
REQ-025 Shared package sobel_pkg holds: CONV_W, SQRT_IN_W, SQRT_OUT_W and WIN defaults; the state encoding as a typedef; and the sum width constant.
REQ-026 Sub-module sobel_mag_sq is combinational and computes abs/square/add for one pair. The FSM, buffers and divide-by-WIN stay in sobel_mag_sched.

Verification
REQ-027 Uniform frame: WIN pairs (3,4), mock sqrt root 5 at 3-cycle latency -> nine sq_num=25, sum=45, thr=5, all out_edge=0, out_last only on the 9th, one frame_done.
REQ-028 Single edge: pair 4 = (30,-40), the rest (0,0) -> root[4]=50, sum=50, thr=5, out_edge=1 only at index 4.
REQ-029 Extreme value: ix=-2^28, iy=-2^28 -> sq_num=2^57 exactly, with no sign or overflow error.
REQ-030 Backpressure: out_ready toggles 1/0 every cycle, and in_valid idles randomly in COLLECT -> same 9 decisions as without stalls, and outputs stay stable while stalled.
REQ-031 Spurious done: sq_done pulsed in COLLECT and in EMIT -> no state, sum or root change.
REQ-032 Reset mid-SQ_WAIT at k=5, then sq_done arrives after release -> all outputs 0 and state IDLE; the next frame produces correct results from k=0.
